// File: rtl/m2_fsl_rx_deframer.sv
// M2 FSL receive deframer: FIFO-buffered header/payload parser onto a valid/ready stream.
// Optional saturating statistics counters are built when M2_RX_STATS_EN is defined.
module m2_fsl_rx_deframer #(
   parameter int C_DEPTH     = 16,
   parameter int C_LOG_DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_fsl_write,
   input  logic [0:63] i_fsl_data,
   input  logic        i_fsl_control,
   output logic        o_fsl_full,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [0:63] o_data,
   output logic        o_hdr,
   output logic        o_last,
   output logic        o_err_orphan,
   output logic        o_err_trunc,
   output logic        o_err_ovf,
   output logic [0:31] o_stat_msgs,
   output logic [0:31] o_stat_errs
);

   typedef enum logic [0:0] {S_IDLE, S_PAYLOAD} state_t;

   localparam logic [C_LOG_DEPTH:0] LP_FULL = (C_LOG_DEPTH+1)'(C_DEPTH);

   logic [64:0]            r_mem [C_DEPTH];
   logic [C_LOG_DEPTH-1:0] r_wptr;
   logic [C_LOG_DEPTH-1:0] r_rptr;
   logic [C_LOG_DEPTH:0]   r_count;
   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [15:0]            r_rem;
   logic [15:0]            w_rem_nxt;

   logic        w_empty;
   logic        w_wr;
   logic        w_pop;
   logic [64:0] w_head;
   logic        w_head_ctl;
   logic [0:63] w_head_data;
   logic [15:0] w_len;
   logic        w_hdr_acc;

   assign w_empty     = (r_count == '0);
   assign o_fsl_full  = (r_count == LP_FULL);
   // A write against a full FIFO is dropped even if a pop frees a slot this cycle.
   assign w_wr        = i_fsl_write & ~o_fsl_full;
   assign o_err_ovf   = i_fsl_write & o_fsl_full;
   assign w_head      = r_mem[r_rptr];
   assign w_head_ctl  = w_head[64];
   assign w_head_data = w_head[63:0];
   assign w_len       = w_head_data[0:15];
   assign o_data      = o_valid ? w_head_data : '0;

   always_ff @(posedge i_clk) begin
      if (w_wr) begin
         r_mem[r_wptr] <= {i_fsl_control, i_fsl_data};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_state <= S_IDLE;
         r_rem   <= '0;
      end else begin
         if (w_wr) begin
            r_wptr <= r_wptr + C_LOG_DEPTH'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + C_LOG_DEPTH'(1);
         end
         r_count <= r_count + (C_LOG_DEPTH+1)'(w_wr)
                            - (C_LOG_DEPTH+1)'(w_pop);
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_rem_nxt    = r_rem;
      w_pop        = 1'b0;
      w_hdr_acc    = 1'b0;
      o_valid      = 1'b0;
      o_hdr        = 1'b0;
      o_last       = 1'b0;
      o_err_orphan = 1'b0;
      o_err_trunc  = 1'b0;
      if (!w_empty) begin
         unique case (r_state)
            S_IDLE: begin
               if (w_head_ctl) begin
                  o_valid = 1'b1;
                  o_hdr   = 1'b1;
                  o_last  = (w_len == 16'd0);
                  if (i_ready) begin
                     w_pop       = 1'b1;
                     w_hdr_acc   = 1'b1;
                     w_rem_nxt   = w_len;
                     w_state_nxt = (w_len != 16'd0) ? S_PAYLOAD : S_IDLE;
                  end
               end else begin
                  w_pop        = 1'b1;
                  o_err_orphan = 1'b1;
               end
            end
            S_PAYLOAD: begin
               if (!w_head_ctl) begin
                  o_valid = 1'b1;
                  o_last  = (r_rem == 16'd1);
                  if (i_ready) begin
                     w_pop = 1'b1;
                     if (r_rem != 16'd0) begin
                        w_rem_nxt = r_rem - 16'd1;
                     end
                     if (r_rem <= 16'd1) begin
                        w_state_nxt = S_IDLE;
                     end
                  end
               end else begin
                  // Header left in place; it is parsed from IDLE next cycle.
                  o_err_trunc = 1'b1;
                  w_rem_nxt   = '0;
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

`ifdef M2_RX_STATS_EN
   logic [31:0] r_msgs;
   logic [31:0] r_errs;
   logic [1:0]  w_err_inc;
   logic [32:0] w_errs_sum;

   assign w_err_inc  = 2'(o_err_orphan) + 2'(o_err_trunc) + 2'(o_err_ovf);
   assign w_errs_sum = {1'b0, r_errs} + 33'(w_err_inc);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_msgs <= '0;
         r_errs <= '0;
      end else begin
         if (w_hdr_acc && (r_msgs != 32'hFFFF_FFFF)) begin
            r_msgs <= r_msgs + 32'd1;
         end
         r_errs <= w_errs_sum[32] ? 32'hFFFF_FFFF : w_errs_sum[31:0];
      end
   end

   assign o_stat_msgs = r_msgs;
   assign o_stat_errs = r_errs;
`else
   assign o_stat_msgs = '0;
   assign o_stat_errs = '0;
`endif

endmodule
